// File: rtl/prvp_spi_pkg.sv
// Shared types and lane helpers for the multi-lane SPI transmit path.
// Lane counts are clamped to the physical lane count of the instance.
package prvp_spi_pkg;

  typedef enum logic [1:0] {
    SINGLE,
    DUAL,
    QUAD,
    OCTAL
  } lane_mode_e;

  typedef enum logic [1:0] {
    IDLE,
    TRANSMIT,
    STALL
  } tx_state_e;

  function automatic int lanes_of(
    input lane_mode_e mode,
    input int         max_lanes
  );
    int l;
    l = 1 << mode;
    return (l > max_lanes) ? max_lanes : l;
  endfunction

  function automatic logic [1:0] lanes_log(
    input lane_mode_e mode,
    input int         max_lanes
  );
    int l;
    l = lanes_of(mode, max_lanes);
    case (l)
      1:       return 2'd0;
      2:       return 2'd1;
      4:       return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/prvp_spi_tx_shreg.sv
// TX shift register: parallel load, shift by lane count, lane extraction.
// Lanes beyond the active count read as zero.
module prvp_spi_tx_shreg #(
  parameter int DATA_W    = 32,
  parameter int MAX_LANES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 shift,
  input  logic                 clear,
  input  logic                 lsb_first,
  input  logic [1:0]           lane_lg,
  input  logic [DATA_W-1:0]    din,
  output logic [MAX_LANES-1:0] lanes
);

  localparam int AW = $clog2(DATA_W);

  logic [DATA_W-1:0] q;
  logic [3:0]        nl;

  assign nl = 4'd1 << lane_lg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= lsb_first ? (q >> nl) : (q << nl);
    end
  end

  always_comb begin
    lanes = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (i < int'(nl)) begin
        if (lsb_first) begin
          lanes[i] = q[i];
        end else begin
          lanes[i] = q[AW'(DATA_W - int'(nl) + i)];
        end
      end
    end
  end

endmodule

// File: rtl/prvp_spi_master_tx_ml.sv
// Multi-lane SPI master TX engine: word handshake, beat/word counters,
// underrun stall and abort, paced by the clock generator's tx_edge.
module prvp_spi_master_tx_ml
  import prvp_spi_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 16,
  parameter int MAX_LANES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 tx_edge,
  input  logic [1:0]           lane_mode,
  input  logic                 lsb_first,
  input  logic                 abort,
  input  logic [CNT_W-1:0]     counter_in,
  input  logic                 counter_in_upd,
  input  logic [DATA_W-1:0]    data,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic [MAX_LANES-1:0] sdo,
  output logic [MAX_LANES-1:0] sdo_oe,
  output logic                 clk_en_o,
  output logic                 tx_done,
  output logic                 busy,
  output logic                 underrun
);

  localparam int AW = $clog2(DATA_W);

  tx_state_e         state, nstate;
  logic [CNT_W-1:0]  beat_cnt;
  logic [CNT_W-1:0]  tgt;
  logic [CNT_W-1:0]  pend;
  logic [CNT_W-1:0]  nt;
  logic              pend_v;
  logic [AW-1:0]     wbeat;
  logic [1:0]        lg_q;
  logic              lsb_q;
  logic [3:0]        nl;
  logic [CNT_W:0]    beats;
  logic [AW:0]       bpw;
  logic              last;
  logic              wlast;
  logic              ld;
  logic              sh;
  logic              clr;
  logic              b_inc;
  logic              b_clr;
  logic              w_clr;
  logic              latch;
  logic              apply;
  logic [MAX_LANES-1:0] raw;

  assign nl    = 4'd1 << lg_q;
  assign beats = ({1'b0, tgt} + (CNT_W+1)'(nl - 4'd1)) >> lg_q;
  assign bpw   = (AW+1)'(DATA_W) >> lg_q;
  assign last  = ((CNT_W+1)'(beat_cnt) + (CNT_W+1)'(1)) == beats;
  assign wlast = ((AW+1)'(wbeat) + (AW+1)'(1)) == bpw;
  assign busy  = (state != IDLE);

  // Target seen by the next transfer: a same-cycle strobe beats the shadow.
  assign nt = counter_in_upd ? counter_in : (pend_v ? pend : tgt);

  always_comb begin
    nstate     = state;
    ld         = 1'b0;
    sh         = 1'b0;
    clr        = 1'b0;
    b_inc      = 1'b0;
    b_clr      = 1'b0;
    w_clr      = 1'b0;
    latch      = 1'b0;
    apply      = 1'b0;
    data_ready = 1'b0;
    tx_done    = 1'b0;
    underrun   = 1'b0;
    clk_en_o   = 1'b0;
    if (!rst) begin
      if (state != IDLE && abort) begin
        nstate = IDLE;
        clr    = 1'b1;
        b_clr  = 1'b1;
        apply  = 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (en && data_valid && nt != '0) begin
              ld         = 1'b1;
              latch      = 1'b1;
              data_ready = 1'b1;
              nstate     = TRANSMIT;
            end
          end
          TRANSMIT: begin
            clk_en_o = 1'b1;
            if (tx_edge) begin
              if (last) begin
                tx_done = 1'b1;
                b_clr   = 1'b1;
                apply   = 1'b1;
                if (en && data_valid && nt != '0) begin
                  ld         = 1'b1;
                  latch      = 1'b1;
                  data_ready = 1'b1;
                end else begin
                  nstate   = IDLE;
                  clk_en_o = 1'b0;
                end
              end else if (wlast) begin
                b_inc = 1'b1;
                w_clr = 1'b1;
                if (data_valid) begin
                  ld         = 1'b1;
                  data_ready = 1'b1;
                end else begin
                  nstate   = STALL;
                  underrun = 1'b1;
                  clk_en_o = 1'b0;
                end
              end else begin
                sh    = 1'b1;
                b_inc = 1'b1;
              end
            end
          end
          STALL: begin
            if (data_valid) begin
              ld         = 1'b1;
              data_ready = 1'b1;
              nstate     = TRANSMIT;
            end
          end
          default: nstate = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
      wbeat    <= '0;
      tgt      <= CNT_W'(8);
      pend     <= '0;
      pend_v   <= 1'b0;
      lg_q     <= 2'd0;
      lsb_q    <= 1'b0;
    end else begin
      state <= nstate;
      if (b_clr) begin
        beat_cnt <= '0;
        wbeat    <= '0;
      end else if (b_inc) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
        wbeat    <= w_clr ? '0 : wbeat + AW'(1);
      end
      if (latch) begin
        lg_q  <= lanes_log(lane_mode_e'(lane_mode), MAX_LANES);
        lsb_q <= lsb_first;
      end
      if (state == IDLE || apply) begin
        tgt    <= nt;
        pend_v <= 1'b0;
      end else if (counter_in_upd) begin
        pend   <= counter_in;
        pend_v <= 1'b1;
      end
    end
  end

  prvp_spi_tx_shreg #(
    .DATA_W   (DATA_W),
    .MAX_LANES(MAX_LANES)
  ) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .load     (ld),
    .shift    (sh),
    .clear    (clr),
    .lsb_first(lsb_q),
    .lane_lg  (lg_q),
    .din      (data),
    .lanes    (raw)
  );

  always_comb begin
    sdo    = raw & {MAX_LANES{busy}};
    sdo_oe = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      sdo_oe[i] = busy && (i < int'(nl));
    end
  end

endmodule

// File: tb/tb_prvp_spi_master_tx_ml.sv
// Scoreboard bench for prvp_spi_master_tx_ml: expected beats are queued
// from a bit-index model and checked as each beat leaves the shifter.
`timescale 1ns/1ps
module tb_prvp_spi_master_tx_ml;

  localparam int DW = 32;
  localparam int CW = 16;
  localparam int ML = 4;

  typedef struct packed {
    logic [ML-1:0] sdo;
    logic          done;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          tx_edge = 1'b0;
  logic [1:0]    lane_mode = 2'd0;
  logic          lsb_first = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] counter_in = '0;
  logic          counter_in_upd = 1'b0;
  logic [DW-1:0] data = '0;
  logic          data_valid = 1'b0;
  logic          data_ready;
  logic [ML-1:0] sdo;
  logic [ML-1:0] sdo_oe;
  logic          clk_en_o;
  logic          tx_done;
  logic          busy;
  logic          underrun;

  exp_t          sb[$];
  logic [DW-1:0] fq[$];
  int compared = 0;
  int mismatched = 0;
  int beats_seen = 0;
  int done_cnt = 0;
  int urun_cnt = 0;
  int rdy_cnt = 0;
  bit acc = 1'b0;
  int ediv = 0;

  always #5 clk = ~clk;

  prvp_spi_master_tx_ml #(
    .DATA_W(DW), .CNT_W(CW), .MAX_LANES(ML)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .tx_edge(tx_edge),
    .lane_mode(lane_mode), .lsb_first(lsb_first), .abort(abort),
    .counter_in(counter_in), .counter_in_upd(counter_in_upd),
    .data(data), .data_valid(data_valid), .data_ready(data_ready),
    .sdo(sdo), .sdo_oe(sdo_oe), .clk_en_o(clk_en_o),
    .tx_done(tx_done), .busy(busy), .underrun(underrun)
  );

  // tx_edge strobe every second cycle
  always @(posedge clk) begin
    #1;
    ediv++;
    tx_edge = ediv[0];
  end

  // word feeder: pop after an accepted handshake
  always @(posedge clk) begin
    #1;
    if (acc && fq.size() > 0) fq.delete(0);
    data_valid = fq.size() > 0;
    data = (fq.size() > 0) ? fq[0] : '0;
  end

  // beat monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    acc = data_valid && data_ready;
    if (data_ready) rdy_cnt++;
    if (tx_done) done_cnt++;
    if (underrun) urun_cnt++;
    if (!rst && tx_edge && busy && (clk_en_o || underrun || tx_done)) begin
      beats_seen++;
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL extra_beat: sdo=%h done=%b, required no beat",
                 sdo, tx_done);
      end else begin
        e = sb.pop_front();
        if (sdo !== e.sdo || tx_done !== e.done) begin
          mismatched++;
          $display("FAIL beat%0d: sdo=%h done=%b, required sdo=%h done=%b",
                   beats_seen, sdo, tx_done, e.sdo, e.done);
        end
      end
    end
  end

  task automatic push_xfer(
    input logic [DW-1:0] w0,
    input logic [DW-1:0] w1,
    input int nbits,
    input int l,
    input bit lsb,
    input int keep
  );
    int beats, bpw, k, idx;
    logic [DW-1:0] w;
    exp_t e;
    beats = (nbits + l - 1) / l;
    bpw = DW / l;
    for (int b = 0; b < beats && b < keep; b++) begin
      w = (b / bpw == 0) ? w0 : w1;
      k = b % bpw;
      e = '0;
      for (int i = 0; i < l; i++) begin
        idx = lsb ? l * k + i : DW - l * (k + 1) + i;
        e.sdo[i] = w[idx];
      end
      e.done = (b == beats - 1);
      sb.push_back(e);
    end
  endtask

  task automatic set_count(input int n);
    @(posedge clk); #1;
    counter_in = CW'(n);
    counter_in_upd = 1'b1;
    @(posedge clk); #1;
    counter_in_upd = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < max; c++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) begin
        ok = 1'b1;
        return;
      end
    end
    sb.delete();
  endtask

  task automatic test_reset();
    bit ok;
    int d0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    compared++;
    if ({busy, clk_en_o, tx_done, underrun, data_ready} !== 5'b0) begin
      mismatched++;
      $display("FAIL reset_ctl: got %b, required 00000",
               {busy, clk_en_o, tx_done, underrun, data_ready});
    end
    compared++;
    if (sdo !== '0 || sdo_oe !== '0) begin
      mismatched++;
      $display("FAIL reset_lanes: sdo=%h oe=%h, required 0/0", sdo, sdo_oe);
    end
    // untouched target is 8 bits after reset
    d0 = done_cnt;
    en = 1'b1;
    push_xfer(32'h5A3C_0000, 32'h0, 8, 1, 1'b0, 99);
    fq.push_back(32'h5A3C_0000);
    wait_done(200, ok);
    compared++;
    if (!ok || done_cnt - d0 != 1) begin
      mismatched++;
      $display("FAIL reset_target: ok=%b done=%0d, required ok=1 done=1",
               ok, done_cnt - d0);
    end
  endtask

  task automatic test_single_msb();
    bit ok;
    int d0, u0;
    set_count(32);
    lane_mode = 2'd0;
    d0 = done_cnt;
    u0 = urun_cnt;
    push_xfer(32'hA5A5_0F0F, 32'h0, 32, 1, 1'b0, 99);
    fq.push_back(32'hA5A5_0F0F);
    wait_done(300, ok);
    compared++;
    if (!ok || done_cnt - d0 != 1 || urun_cnt != u0) begin
      mismatched++;
      $display("FAIL single_end: ok=%b done=%0d urun=%0d, required 1/1/0",
               ok, done_cnt - d0, urun_cnt - u0);
    end
    compared++;
    if (clk_en_o !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL single_idle: clk_en=%b busy=%b, required 0/0",
               clk_en_o, busy);
    end
  endtask

  task automatic test_quad();
    bit ok, seen;
    int d0, r0;
    set_count(64);
    lane_mode = 2'd2;
    d0 = done_cnt;
    r0 = rdy_cnt;
    push_xfer(32'h1234_5678, 32'h9ABC_DEF0, 64, 4, 1'b0, 99);
    fq.push_back(32'h1234_5678);
    fq.push_back(32'h9ABC_DEF0);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = busy;
    end
    compared++;
    if (!seen || sdo !== 4'h1 || sdo_oe !== 4'hF) begin
      mismatched++;
      $display("FAIL quad_first: busy=%b sdo=%h oe=%h, required 1/1/f",
               seen, sdo, sdo_oe);
    end
    wait_done(300, ok);
    compared++;
    if (!ok || done_cnt - d0 != 1 || rdy_cnt - r0 != 2) begin
      mismatched++;
      $display("FAIL quad_end: ok=%b done=%0d rdy=%0d, required 1/1/2",
               ok, done_cnt - d0, rdy_cnt - r0);
    end
  endtask

  task automatic test_stall();
    bit ok, seen;
    int d0, u0, b0;
    set_count(64);
    lane_mode = 2'd1;
    d0 = done_cnt;
    u0 = urun_cnt;
    b0 = beats_seen;
    push_xfer(32'hF00D_C0DE, 32'h3C3C_A5A5, 64, 2, 1'b0, 99);
    fq.push_back(32'hF00D_C0DE);
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      seen = underrun;
    end
    compared++;
    if (!seen || clk_en_o !== 1'b0) begin
      mismatched++;
      $display("FAIL stall_entry: urun=%b clk_en=%b, required 1/0",
               seen, clk_en_o);
    end
    @(negedge clk);
    compared++;
    if (busy !== 1'b1 || clk_en_o !== 1'b0 || sdo_oe !== 4'b0011
        || beats_seen - b0 != 16) begin
      mismatched++;
      $display("FAIL stall_hold: busy=%b clk_en=%b oe=%h beats=%0d, %s",
               busy, clk_en_o, sdo_oe, beats_seen - b0,
               "required 1/0/3/16");
    end
    repeat (20) @(negedge clk);
    compared++;
    if (beats_seen - b0 != 16 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL stall_frozen: beats=%0d busy=%b, required 16/1",
               beats_seen - b0, busy);
    end
    fq.push_back(32'h3C3C_A5A5);
    wait_done(300, ok);
    compared++;
    if (!ok || done_cnt - d0 != 1 || urun_cnt - u0 != 1
        || beats_seen - b0 != 32) begin
      mismatched++;
      $display("FAIL stall_end: ok=%b done=%0d urun=%0d beats=%0d, %s",
               ok, done_cnt - d0, urun_cnt - u0, beats_seen - b0,
               "required 1/1/1/32");
    end
  endtask

  task automatic test_lsb();
    bit ok;
    int d0;
    set_count(8);
    lane_mode = 2'd0;
    lsb_first = 1'b1;
    d0 = done_cnt;
    push_xfer(32'h0000_0001, 32'h0, 8, 1, 1'b1, 99);
    fq.push_back(32'h0000_0001);
    wait_done(200, ok);
    compared++;
    if (!ok || done_cnt - d0 != 1) begin
      mismatched++;
      $display("FAIL lsb_end: ok=%b done=%0d, required 1/1",
               ok, done_cnt - d0);
    end
    lsb_first = 1'b0;
  endtask

  task automatic test_abort();
    bit seen;
    int d0, b0;
    set_count(32);
    lane_mode = 2'd2;
    d0 = done_cnt;
    b0 = beats_seen;
    push_xfer(32'hDEAD_BEEF, 32'h0, 32, 4, 1'b0, 4);
    fq.push_back(32'hDEAD_BEEF);
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      seen = (beats_seen - b0 >= 4);
    end
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    compared++;
    if (!seen || busy !== 1'b0 || sdo !== '0 || sdo_oe !== '0
        || clk_en_o !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_idle: busy=%b sdo=%h oe=%h clk_en=%b, %s",
               busy, sdo, sdo_oe, clk_en_o, "required 0/0/0/0");
    end
    compared++;
    if (done_cnt != d0 || sb.size() != 0 || beats_seen - b0 != 4) begin
      mismatched++;
      $display("FAIL abort_count: done=%0d left=%0d beats=%0d, %s",
               done_cnt - d0, sb.size(), beats_seen - b0,
               "required 0/0/4");
    end
    sb.delete();
  endtask

  task automatic test_b2b_update();
    bit ok, seen;
    int d0, r0, b0;
    set_count(32);
    lane_mode = 2'd0;
    d0 = done_cnt;
    r0 = rdy_cnt;
    b0 = beats_seen;
    push_xfer(32'hC3A5_1E77, 32'h0, 32, 1, 1'b0, 99);
    push_xfer(32'h6B2D_9F41, 32'h0, 24, 1, 1'b0, 99);
    fq.push_back(32'hC3A5_1E77);
    fq.push_back(32'h6B2D_9F41);
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      seen = (beats_seen - b0 >= 10);
    end
    @(posedge clk); #1;
    counter_in = CW'(24);
    counter_in_upd = 1'b1;
    @(posedge clk); #1 counter_in_upd = 1'b0;
    wait_done(400, ok);
    compared++;
    if (!seen || !ok || done_cnt - d0 != 2 || rdy_cnt - r0 != 2
        || beats_seen - b0 != 56) begin
      mismatched++;
      $display("FAIL b2b_end: ok=%b done=%0d rdy=%0d beats=%0d, %s",
               ok, done_cnt - d0, rdy_cnt - r0, beats_seen - b0,
               "required 1/2/2/56");
    end
  endtask

  task automatic test_zero_count();
    bit any_busy;
    int r0;
    set_count(0);
    lane_mode = 2'd0;
    r0 = rdy_cnt;
    any_busy = 1'b0;
    fq.push_back(32'hFFFF_FFFF);
    repeat (12) begin
      @(negedge clk);
      if (busy) any_busy = 1'b1;
    end
    compared++;
    if (rdy_cnt != r0 || any_busy) begin
      mismatched++;
      $display("FAIL zero_count: rdy=%0d busy=%b, required 0/0",
               rdy_cnt - r0, any_busy);
    end
    fq.delete();
  endtask

  task automatic test_octal_clamp();
    bit ok, seen;
    int d0, b0;
    set_count(32);
    lane_mode = 2'd3;
    d0 = done_cnt;
    b0 = beats_seen;
    push_xfer(32'hCAFE_BABE, 32'h0, 32, 4, 1'b0, 99);
    fq.push_back(32'hCAFE_BABE);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = busy;
    end
    compared++;
    if (!seen || sdo_oe !== 4'hF) begin
      mismatched++;
      $display("FAIL octal_oe: busy=%b oe=%h, required 1/f", seen, sdo_oe);
    end
    wait_done(200, ok);
    compared++;
    if (!ok || done_cnt - d0 != 1 || beats_seen - b0 != 8) begin
      mismatched++;
      $display("FAIL octal_end: ok=%b done=%0d beats=%0d, required 1/1/8",
               ok, done_cnt - d0, beats_seen - b0);
    end
  endtask

  initial begin
    test_reset();
    test_single_msb();
    test_quad();
    test_stall();
    test_lsb();
    test_abort();
    test_b2b_update();
    test_zero_count();
    test_octal_clamp();
    en = 1'b0;
    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
